// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: widths, the canonical NOP and the fetch FSM state encoding.
package riscv_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the memory, decode and redirect signals of the fetch unit; master is the fetch unit side.
interface instr_fetch_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
) ();
    import riscv_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_rvalid;
    logic [ILEN-1:0]   imem_rdata;

    // Decode handshake: a transfer happens on a rising edge where instr_valid & instr_ready;
    // instr/instr_pc are held unchanged while instr_valid=1 and the transfer has not happened.
    logic              instr_valid;
    logic              instr_ready;
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   instr_pc;

    logic              redirect_valid;
    logic              redirect_jalr;
    logic [XLEN-1:0]   redirect_base;
    logic [XLEN-1:0]   redirect_imm;
    logic [XLEN-1:0]   redirect_rs1;
    logic              misalign_err;

    fetch_state_t      dbg_state;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err, dbg_state,
        input  imem_rvalid, imem_rdata, instr_ready,
        input  redirect_valid, redirect_jalr, redirect_base, redirect_imm, redirect_rs1
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err, dbg_state,
        output imem_rvalid, imem_rdata, instr_ready,
        output redirect_valid, redirect_jalr, redirect_base, redirect_imm, redirect_rs1
    );
endinterface

// File: rtl/next_pc_calc.sv
// Redirect target adder: base+imm for branch/JAL, (rs1+imm)&~1 for JALR, plus a 4-byte misalignment flag.
module next_pc_calc #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            i_jalr,
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    output logic [XLEN-1:0] o_target,
    output logic            o_misaligned
);
    logic [XLEN-1:0] w_sum;

    always_comb begin
        w_sum        = i_jalr ? (i_rs1 + i_imm) : (i_base + i_imm);
        o_target     = {w_sum[XLEN-1:1], w_sum[0] & ~i_jalr};
        o_misaligned = o_target[1];
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: FETCH -> WAIT -> HOLD loop with redirect override and sticky HALT.
module instr_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    import riscv_pkg::*;

    fetch_state_t     r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_drop;
    logic             r_instr_valid;
    logic [ILEN-1:0]  r_instr;
    logic [XLEN-1:0]  r_instr_pc;
    logic             r_misalign;

    logic [XLEN-1:0]  w_target;
    logic             w_misaligned;
    logic             w_outstanding;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
        .i_jalr       (bus.redirect_jalr),
        .i_base       (bus.redirect_base),
        .i_imm        (bus.redirect_imm),
        .i_rs1        (bus.redirect_rs1),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // A response arriving in the same cycle as the redirect is consumed now, so nothing is left to drop.
    assign w_outstanding = (r_state == WAIT) && !bus.imem_rvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
            r_misalign    <= 1'b0;
        end else if (bus.redirect_valid && (r_state != HALT)) begin
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
                r_misalign <= 1'b1;
                r_drop     <= 1'b0;
                r_state    <= HALT;
            end else begin
                r_pc <= w_target;
                if (w_outstanding) begin
                    r_drop  <= 1'b1;
                    r_state <= WAIT;
                end else begin
                    r_drop  <= 1'b0;
                    r_state <= FETCH;
                end
            end
        end else begin
            case (r_state)
                FETCH: r_state <= WAIT;
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= FETCH;
                        end else begin
                            r_instr       <= bus.imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= r_pc + XLEN'(4);
                            r_state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= FETCH;
                    end
                end
                default: r_state <= HALT;
            endcase
        end
    end

    assign bus.imem_req     = rst_n && (r_state == FETCH) && !bus.redirect_valid;
    assign bus.imem_addr    = r_pc;
    assign bus.instr_valid  = r_instr_valid;
    assign bus.instr        = r_instr;
    assign bus.instr_pc     = r_instr_pc;
    assign bus.misalign_err = r_misalign;
    assign bus.dbg_state    = r_state;
endmodule
